// File: rtl/ticket_pkg.sv
// Shared constants and types for the ticket-machine key/coin front-end.
// STUCK_DETECT_EN adds the STUCK debounce state.
package ticket_pkg;
  localparam int NUM_CH   = 7;
  localparam int NUM_COIN = 5;

  localparam int CH_SURE  = 0;
  localparam int CH_NSURE = 1;
  localparam int CH_CI1   = 2;
  localparam int CH_CI5   = 3;
  localparam int CH_CI10  = 4;
  localparam int CH_CI50  = 5;
  localparam int CH_CI100 = 6;

  localparam logic [7:0] COIN_1   = 8'd1;
  localparam logic [7:0] COIN_5   = 8'd5;
  localparam logic [7:0] COIN_10  = 8'd10;
  localparam logic [7:0] COIN_50  = 8'd50;
  localparam logic [7:0] COIN_100 = 8'd100;

`ifdef STUCK_DETECT_EN
  typedef enum logic [2:0] {IDLE, PRESS_CHK, HELD, REL_CHK, STUCK} deb_state_e;
`else
  typedef enum logic [2:0] {IDLE, PRESS_CHK, HELD, REL_CHK} deb_state_e;
`endif

  // One-hot coin pulse {ci100,ci50,ci10,ci5,ci1} to its face value.
  function automatic logic [7:0] coin_val(input logic [NUM_COIN-1:0] onehot);
    case (onehot)
      5'b00001: coin_val = COIN_1;
      5'b00010: coin_val = COIN_5;
      5'b00100: coin_val = COIN_10;
      5'b01000: coin_val = COIN_50;
      5'b10000: coin_val = COIN_100;
      default:  coin_val = 8'd0;
    endcase
  endfunction
endpackage

// File: rtl/coin_key_conditioner_if.sv
// Raw key inputs and conditioned pulse outputs of the key/coin front-end.
interface coin_key_conditioner_if;
  import ticket_pkg::*;
  logic [NUM_CH-1:0]   raw_key;
  logic                sure_p;
  logic                nsure_p;
  logic [NUM_COIN-1:0] coin_p;
  logic                coin_valid;
  logic [7:0]          coin_value;
  logic                busy;
  logic [NUM_CH-1:0]   stuck;

  modport master (input raw_key,
                  output sure_p, nsure_p, coin_p, coin_valid, coin_value, busy, stuck);
  modport slave  (output raw_key,
                  input sure_p, nsure_p, coin_p, coin_valid, coin_value, busy, stuck);
endinterface

// File: rtl/key_debounce.sv
// One channel: 2-flop synchroniser, debounce FSM and press event.
// STUCK_DETECT_EN adds a hold counter that parks long presses in STUCK.
module key_debounce
  import ticket_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 1_000_000,
  parameter int unsigned DEB_W        = 20,
  parameter int unsigned STUCK_CYCLES = 200_000_000
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic raw,
  output logic evt,
  output logic stuck
);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             sync;
  deb_state_e       state, state_nxt;
  logic [DEB_W-1:0] cnt, cnt_nxt, cnt_inc;

  assign sync    = sync_q[1];
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

`ifdef STUCK_DETECT_EN
  localparam int unsigned HOLD_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STUCK_CYCLES - 1);
  logic [HOLD_W-1:0] hold, hold_nxt, hold_inc;
  assign hold_inc = (hold == '1) ? hold : hold + 1'b1;
  assign stuck    = (state == STUCK);

  always_ff @(posedge clk_sys) begin
    if (!rst) hold <= '0;
    else      hold <= hold_nxt;
  end
`else
  assign stuck = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (!rst) begin
      sync_q <= '0;
      state  <= IDLE;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      state  <= state_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    evt       = 1'b0;
`ifdef STUCK_DETECT_EN
    hold_nxt  = hold;
`endif
    case (state)
      IDLE: if (sync) begin
        state_nxt = PRESS_CHK;
        cnt_nxt   = '0;
      end
      PRESS_CHK: begin
        if (!sync) state_nxt = IDLE;
        else if (cnt == DEB_LAST) begin
          state_nxt = HELD;
          evt       = 1'b1;
`ifdef STUCK_DETECT_EN
          hold_nxt  = '0;
`endif
        end else cnt_nxt = cnt_inc;
      end
      HELD: begin
        if (!sync) begin
          state_nxt = REL_CHK;
          cnt_nxt   = '0;
        end
`ifdef STUCK_DETECT_EN
        else if (hold == HOLD_LAST) begin
          state_nxt = STUCK;
          cnt_nxt   = '0;
        end else hold_nxt = hold_inc;
`endif
      end
      // A bounce back to 1 during release resumes HELD without a new event.
      REL_CHK: begin
        if (sync) state_nxt = HELD;
        else if (cnt == DEB_LAST) state_nxt = IDLE;
        else cnt_nxt = cnt_inc;
      end
`ifdef STUCK_DETECT_EN
      STUCK: begin
        if (sync) cnt_nxt = '0;
        else if (cnt == DEB_LAST) state_nxt = IDLE;
        else cnt_nxt = cnt_inc;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: rtl/coin_key_conditioner.sv
// Ticket-machine key/coin front-end: 7 debounced channels, sure/nsure arbitration
// and a one-coin-per-cycle pending queue. STUCK_DETECT_EN enables stuck-key detection.
module coin_key_conditioner
  import ticket_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 1_000_000,
  parameter int unsigned DEB_W        = 20,
  parameter int unsigned STUCK_CYCLES = 200_000_000
) (
  input  logic                   clk_sys,
  input  logic                   rst,
  coin_key_conditioner_if.master bus
);
  logic [NUM_CH-1:0]   evt, stuck_ch;
  logic [NUM_COIN-1:0] pend, issue;
  logic                sure_q, nsure_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    key_debounce #(
      .DEB_CYCLES  (DEB_CYCLES),
      .DEB_W       (DEB_W),
      .STUCK_CYCLES(STUCK_CYCLES)
    ) u_deb (
      .clk_sys(clk_sys),
      .rst    (rst),
      .raw    (bus.raw_key[g]),
      .evt    (evt[g]),
      .stuck  (stuck_ch[g])
    );
  end

  // Lowest pending coin wins; two's-complement isolates the lowest set bit.
  assign issue = pend & (~pend + 5'd1);

  always_ff @(posedge clk_sys) begin
    if (!rst) begin
      sure_q  <= 1'b0;
      nsure_q <= 1'b0;
      pend    <= '0;
    end else begin
      sure_q  <= evt[CH_SURE] & ~evt[CH_NSURE];
      nsure_q <= evt[CH_NSURE];
      pend    <= (pend & ~issue) | evt[CH_CI100:CH_CI1];
    end
  end

  assign bus.sure_p     = sure_q;
  assign bus.nsure_p    = nsure_q;
  assign bus.coin_p     = issue;
  assign bus.coin_valid = |pend;
  assign bus.coin_value = coin_val(issue);
  assign bus.busy       = |pend;
  assign bus.stuck      = stuck_ch;
endmodule

// File: tb/tb_coin_key_conditioner.sv
// Scoreboard bench for coin_key_conditioner (DEB_CYCLES=4, STUCK_CYCLES=20).
// Build with STUCK_DETECT_EN defined to also exercise stuck detection.
module tb_coin_key_conditioner;
  import ticket_pkg::*;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;  // drive cycle to output-visible cycle

  logic clk_sys = 1'b0;
  logic rst     = 1'b0;
  int   cyc     = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  coin_key_conditioner_if kif();

  coin_key_conditioner #(
    .DEB_CYCLES  (DEB),
    .DEB_W       (3),
    .STUCK_CYCLES(20)
  ) dut (
    .clk_sys(clk_sys),
    .rst    (rst),
    .bus    (kif)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       sure;
    logic       nsure;
    logic [4:0] coin;
    logic [7:0] val;
    logic       busy;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic s, input logic n, input logic [4:0] co,
                      input logic [7:0] v, input logic b);
    exp_t e;
    e.cyc = c; e.sure = s; e.nsure = n; e.coin = co; e.val = v; e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Scoreboard: any pulse must match the head entry; overdue entries are misses.
  always @(negedge clk_sys) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      chk("missed_pulse_cycle", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (kif.sure_p || kif.nsure_p || kif.coin_valid || kif.coin_p != 5'd0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {kif.sure_p, kif.nsure_p, kif.coin_p}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("sure_p", kif.sure_p, e.sure);
        chk("nsure_p", kif.nsure_p, e.nsure);
        chk("coin_p", kif.coin_p, e.coin);
        chk("coin_valid", kif.coin_valid, |e.coin);
        chk("coin_value", kif.coin_value, e.val);
        chk("busy", kif.busy, e.busy);
      end
    end
  end

  initial begin
    int k;
    kif.raw_key = '0;
    rst = 1'b0;
    step(3);
    chk("rst_sure_p", kif.sure_p, 0);
    chk("rst_nsure_p", kif.nsure_p, 0);
    chk("rst_coin_valid", kif.coin_valid, 0);
    chk("rst_coin_value", kif.coin_value, 0);
    chk("rst_busy", kif.busy, 0);
    chk("rst_stuck", kif.stuck, 0);
    rst = 1'b1;
    step(2);

    // ci5 held 10 cycles: one pulse, nothing on release
    k = cyc;
    kif.raw_key[CH_CI5] = 1'b1;
    push(k + LAT, 0, 0, 5'b00010, 8'd5, 1);
    step(10);
    kif.raw_key[CH_CI5] = 1'b0;
    step(20);

    // ci10 toggling every cycle never qualifies
    for (int i = 0; i < 12; i++) begin
      kif.raw_key[CH_CI10] = ~kif.raw_key[CH_CI10];
      step(1);
    end
    kif.raw_key[CH_CI10] = 1'b0;
    step(20);
    chk("ci10_idle", int'(dut.g_ch[CH_CI10].u_deb.state), int'(IDLE));

    // three coins together are serialised lowest-first
    k = cyc;
    kif.raw_key[CH_CI1]   = 1'b1;
    kif.raw_key[CH_CI50]  = 1'b1;
    kif.raw_key[CH_CI100] = 1'b1;
    push(k + LAT,     0, 0, 5'b00001, 8'd1,   1);
    push(k + LAT + 1, 0, 0, 5'b01000, 8'd50,  1);
    push(k + LAT + 2, 0, 0, 5'b10000, 8'd100, 1);
    step(LAT + 3);
    chk("busy_drained", kif.busy, 0);
    kif.raw_key = '0;
    step(20);

    // sure and nsure together: cancel wins
    k = cyc;
    kif.raw_key[CH_SURE]  = 1'b1;
    kif.raw_key[CH_NSURE] = 1'b1;
    push(k + LAT, 0, 1, 5'b00000, 8'd0, 0);
    step(15);
    chk("stuck_default_quiet", kif.stuck, 0);
    kif.raw_key = '0;
    step(20);

    // reset two cycles before ci50 debounce completes
    kif.raw_key[CH_CI50] = 1'b1;
    step(LAT - 2);
    rst = 1'b0;
    kif.raw_key[CH_CI50] = 1'b0;
    step(1);
    rst = 1'b1;
    chk("midrst_coin_valid", kif.coin_valid, 0);
    chk("midrst_busy", kif.busy, 0);
    step(20);
    k = cyc;
    kif.raw_key[CH_CI50] = 1'b1;
    push(k + LAT, 0, 0, 5'b01000, 8'd50, 1);
    step(10);
    kif.raw_key[CH_CI50] = 1'b0;
    step(20);

    // press entirely inside a long reset produces nothing
    rst = 1'b0;
    kif.raw_key[CH_CI1] = 1'b1;
    step(12);
    chk("inrst_coin_valid", kif.coin_valid, 0);
    kif.raw_key[CH_CI1] = 1'b0;
    step(3);
    rst = 1'b1;
    step(20);

`ifdef STUCK_DETECT_EN
    k = cyc;
    kif.raw_key[CH_SURE] = 1'b1;
    push(k + LAT, 1, 0, 5'b00000, 8'd0, 0);
    step(26);
    chk("stuck_before_limit", kif.stuck[CH_SURE], 0);
    step(1);
    chk("stuck_set", kif.stuck[CH_SURE], 1);
    step(3);
    kif.raw_key[CH_SURE] = 1'b0;
    step(12);
    chk("stuck_cleared", kif.stuck[CH_SURE], 0);
    k = cyc;
    kif.raw_key[CH_SURE] = 1'b1;
    push(k + LAT, 1, 0, 5'b00000, 8'd0, 0);
    step(10);
    kif.raw_key[CH_SURE] = 1'b0;
    step(20);
`endif

    step(5);
    chk("expectations_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
